// File: rtl/tipi_serial_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tipi_serial_master rev 1.0 - byte-request master for the TIPI CPLD serial port.
// Defining TIPI_POLL_EN adds autonomous TC polling (poll_tc / poll_changed).
// ---------------------------------------------------------------------------
module tipi_serial_master #(
  parameter int CLK_DIV  = 4,
  parameter int POLL_GAP = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rt,
  input  logic       req_cd,
  input  logic [0:7] req_wdata,
  output logic       rsp_valid,
  output logic [0:7] rsp_rdata,
  output logic       busy,
  output logic       r_clk,
  output logic       r_le,
  output logic       r_rt,
  output logic       r_cd,
  output logic       r_dout,
  input  logic       r_din
`ifdef TIPI_POLL_EN
  ,
  output logic [0:7] poll_tc,
  output logic       poll_changed
`endif
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LD_SETUP   = 4'd1,
    LD_CLK     = 4'd2,
    LD_HOLD    = 4'd3,
    BIT_LO     = 4'd4,
    BIT_HI     = 4'd5,
    LATCH      = 4'd6,
    LATCH_HOLD = 4'd7,
    DONE       = 4'd8
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state, next_state;
  logic [7:0] cnt;
  logic [2:0] idx, idx_next;
  logic       cap_rt, cap_cd;
  logic [0:7] wdata, wdata_next, shreg;
  logic       start, launch, is_poll, phase_end;
  logic       rt_next, cd_next, clk_next, le_next, dout_next;

  assign phase_end  = (cnt == 8'd0);
  assign start      = (state == IDLE) && (req_valid || launch);
  // An autonomous poll always targets TC (rt=1, cd=1); a host request wins.
  assign rt_next    = start ? (req_valid ? req_rt : 1'b1) : cap_rt;
  assign cd_next    = start ? (req_valid ? req_cd : 1'b1) : cap_cd;
  assign wdata_next = (start && req_valid) ? req_wdata : wdata;

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign rsp_valid  = (state == DONE) && !is_poll;

  always_comb begin
    next_state = state;
    idx_next   = idx;
    case (state)
      IDLE:       if (start) next_state = rt_next ? LD_SETUP : BIT_LO;
      LD_SETUP:   if (phase_end) next_state = LD_CLK;
      LD_CLK:     if (phase_end) next_state = LD_HOLD;
      LD_HOLD:    if (phase_end) next_state = BIT_LO;
      BIT_LO:     if (phase_end) next_state = BIT_HI;
      BIT_HI: begin
        if (phase_end) begin
          if (idx == 3'd7) begin
            next_state = cap_rt ? DONE : LATCH;
          end else begin
            next_state = BIT_LO;
            idx_next   = idx + 3'd1;
          end
        end
      end
      LATCH:      if (phase_end) next_state = LATCH_HOLD;
      LATCH_HOLD: if (phase_end) next_state = DONE;
      DONE:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
    if (start) idx_next = 3'd0;
  end

  // Pin values are derived from the state being entered and then registered.
  always_comb begin
    clk_next  = (next_state == LD_CLK) || (next_state == BIT_HI);
    le_next   = (next_state == LD_SETUP) || (next_state == LD_CLK) || (next_state == LATCH);
    dout_next = 1'b0;
    if ((next_state == BIT_LO) && !rt_next) dout_next = wdata_next[idx_next];
    else if (next_state == BIT_HI)          dout_next = r_dout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      idx       <= 3'd0;
      cap_rt    <= 1'b0;
      cap_cd    <= 1'b0;
      wdata     <= 8'h00;
      shreg     <= 8'h00;
      rsp_rdata <= 8'h00;
      r_clk     <= 1'b0;
      r_le      <= 1'b0;
      r_rt      <= 1'b0;
      r_cd      <= 1'b0;
      r_dout    <= 1'b0;
    end else begin
      state <= next_state;
      idx   <= idx_next;
      if (next_state != state) cnt <= DIV_LAST;
      else if (!phase_end)     cnt <= cnt - 8'd1;
      if (start) begin
        cap_rt <= rt_next;
        cap_cd <= cd_next;
        wdata  <= wdata_next;
      end
      if ((state == BIT_LO) && phase_end) shreg[idx] <= r_din;
      if ((state == BIT_HI) && (next_state == DONE) && !is_poll) rsp_rdata <= shreg;
      r_clk  <= clk_next;
      r_le   <= le_next;
      r_dout <= dout_next;
      r_rt   <= (next_state != IDLE) && rt_next;
      r_cd   <= (next_state != IDLE) && cd_next;
    end
  end

`ifdef TIPI_POLL_EN
  localparam int               GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  logic [GAP_W-1:0] idle_cnt;

  assign launch = (state == IDLE) && !req_valid && (idle_cnt == GAP_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt     <= '0;
      is_poll      <= 1'b0;
      poll_tc      <= 8'h00;
      poll_changed <= 1'b0;
    end else begin
      if ((state == IDLE) && !req_valid && !launch) idle_cnt <= idle_cnt + 1'b1;
      else                                          idle_cnt <= '0;
      if (start) is_poll <= !req_valid;
      poll_changed <= 1'b0;
      if (is_poll && (state == BIT_HI) && (next_state == DONE)) begin
        poll_tc      <= shreg;
        poll_changed <= (shreg != poll_tc);
      end
    end
  end
`else
  // Without polling nothing but a host request ever leaves IDLE.
  assign launch  = (POLL_GAP < 0);
  assign is_poll = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tipi_serial_master.sv
`default_nettype none
// tb_tipi_serial_master - directed bench: DUT a at CLK_DIV=2, DUT b at CLK_DIV=1,
// each with a small CPLD shift-register model serving a TC byte.
module tb_tipi_serial_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       req_rt, req_cd;
  logic [0:7] req_wdata;

  logic       a_req_valid, a_req_ready, a_rsp_valid, a_busy;
  logic       a_r_clk, a_r_le, a_r_rt, a_r_cd, a_r_dout, a_r_din;
  logic [0:7] a_rsp_rdata;
  logic       b_req_valid, b_req_ready, b_rsp_valid, b_busy;
  logic       b_r_clk, b_r_le, b_r_rt, b_r_cd, b_r_dout, b_r_din;
  logic [0:7] b_rsp_rdata;
`ifdef TIPI_POLL_EN
  logic [0:7] a_poll_tc, b_poll_tc;
  logic       a_poll_changed, b_poll_changed;
`endif

  tipi_serial_master #(.CLK_DIV(2), .POLL_GAP(4000)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_rt(req_rt), .req_cd(req_cd), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .busy(a_busy),
    .r_clk(a_r_clk), .r_le(a_r_le), .r_rt(a_r_rt), .r_cd(a_r_cd),
    .r_dout(a_r_dout), .r_din(a_r_din)
`ifdef TIPI_POLL_EN
    , .poll_tc(a_poll_tc), .poll_changed(a_poll_changed)
`endif
  );

  tipi_serial_master #(.CLK_DIV(1), .POLL_GAP(8)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_rt(req_rt), .req_cd(req_cd), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .busy(b_busy),
    .r_clk(b_r_clk), .r_le(b_r_le), .r_rt(b_r_rt), .r_cd(b_r_cd),
    .r_dout(b_r_dout), .r_din(b_r_din)
`ifdef TIPI_POLL_EN
    , .poll_tc(b_poll_tc), .poll_changed(b_poll_changed)
`endif
  );

  // CPLD model: parallel load on an r_clk rise with r_le high, else shift MSB-first.
  logic [0:7] a_tc, a_sh, b_tc, b_sh;
  logic       a_ck_q, b_ck_q;
  always @(negedge clk) begin
    if (a_r_clk && !a_ck_q) a_sh = a_r_le ? a_tc : {a_sh[1:7], 1'b0};
    if (b_r_clk && !b_ck_q) b_sh = b_r_le ? b_tc : {b_sh[1:7], 1'b0};
    a_ck_q = a_r_clk;
    b_ck_q = b_r_clk;
  end
  assign a_r_din = a_sh[0];
  assign b_r_din = b_sh[0];

  logic       sel;
  logic       m_rsp_valid, m_r_le, m_r_clk, m_r_dout, m_r_rt, m_r_cd, m_req_ready;
  logic [0:7] m_rsp_rdata;
  assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign m_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  assign m_r_le      = sel ? b_r_le      : a_r_le;
  assign m_r_clk     = sel ? b_r_clk     : a_r_clk;
  assign m_r_dout    = sel ? b_r_dout    : a_r_dout;
  assign m_r_rt      = sel ? b_r_rt      : a_r_rt;
  assign m_r_cd      = sel ? b_r_cd      : a_r_cd;
  assign m_req_ready = sel ? b_req_ready : a_req_ready;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-cycle history; index c is sampled mid-cycle c, cycle 0 being the accept cycle.
  logic [127:0] h_rv, h_le, h_ck, h_dout, h_rt, h_cd, h_rdy, rises;
  logic [0:7]   rdata_first;

  task automatic watch(input int ncyc, input int drop_at, input logic chg, input logic [0:7] chg_wdata);
    logic got;
    got = 1'b0;
    h_rv = '0; h_le = '0; h_ck = '0; h_dout = '0; h_rt = '0; h_cd = '0; h_rdy = '0;
    rdata_first = 8'h00;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      h_rv[c] = m_rsp_valid; h_le[c] = m_r_le; h_ck[c] = m_r_clk; h_dout[c] = m_r_dout;
      h_rt[c] = m_r_rt;      h_cd[c] = m_r_cd; h_rdy[c] = m_req_ready;
      if (m_rsp_valid && !got) begin
        got = 1'b1;
        rdata_first = m_rsp_rdata;
      end
      if (chg && c == 1) begin
        req_rt = 1'b0; req_cd = 1'b0; req_wdata = chg_wdata;
      end
      if (c == drop_at) begin
        a_req_valid = 1'b0; b_req_valid = 1'b0;
      end
    end
    rises = h_ck & ~(h_ck << 1);
  endtask

  function automatic int first_one(input logic [127:0] v);
    for (int i = 0; i < 128; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] gather(input logic [127:0] pick, input logic [127:0] d);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 128; i++) if (pick[i]) r = {r[6:0], d[i]};
    return r;
  endfunction

`ifdef TIPI_POLL_EN
  task automatic wait_busy(input logic lvl, output int n, output int pc, output int rv);
    n = 0; pc = 0; rv = 0;
    while (b_busy !== lvl && n < 200) begin
      @(negedge clk);
      n++;
      if (b_poll_changed) pc++;
      if (b_rsp_valid) rv++;
    end
    check_vec("busy_wait_bound", {31'd0, b_busy === lvl}, 1);
  endtask
`endif

  initial begin
    int n, pc, rv;
    reset_n = 1'b0; a_req_valid = 1'b0; b_req_valid = 1'b0;
    req_rt = 1'b0; req_cd = 1'b0; req_wdata = 8'h00;
    sel = 1'b0; a_tc = 8'h00; b_tc = 8'h00; a_sh = 8'h00; b_sh = 8'h00;
    a_ck_q = 1'b0; b_ck_q = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("rst_ready", a_req_ready, 1);
    check_vec("rst_busy", a_busy, 0);
    check_vec("rst_pins", {a_r_clk, a_r_le, a_r_rt, a_r_cd, a_r_dout}, 0);
    check_vec("rst_rsp", {a_rsp_valid, a_rsp_rdata}, 0);
    reset_n = 1'b1;

    // CLK_DIV=1 back-to-back read then write, req_valid held across both
    @(negedge clk);
    sel = 1'b1; b_tc = 8'hC3; req_rt = 1'b1; req_cd = 1'b1; req_wdata = 8'h00; b_req_valid = 1'b1;
    check_vec("b2b_ready0", b_req_ready, 1);
    watch(42, 22, 1'b1, 8'h69);
    check_vec("b2b_rsp1_at", first_one(h_rv), 20);
    check_vec("b2b_rsp2_at", h_rv[40], 1);
    check_vec("b2b_rsp_cnt", $countones(h_rv), 2);
    check_vec("b2b_accept2_at", first_one(h_rdy), 21);
    check_vec("b2b_busy_again", h_rdy[22], 0);
    check_vec("b2b_rt_cycles", $countones(h_rt), 20);
    check_vec("b2b_cd_cycles", $countones(h_cd), 20);
    check_vec("b2b_rtcd_idle", {h_rt[21], h_cd[21]}, 0);
    check_vec("b2b_rises", $countones(rises), 17);
    check_vec("b2b_clk_high", $countones(h_ck), 17);
    check_vec("b2b_rdata", rdata_first, 8'hC3);
    check_vec("b2b_wbyte", gather(rises & ~h_rt, h_dout), 8'h69);
    b_tc = 8'h00;

    // CLK_DIV=2 read of TC
    @(negedge clk);
    sel = 1'b0; a_tc = 8'h3C; req_rt = 1'b1; req_cd = 1'b1; a_req_valid = 1'b1;
    check_vec("rd_ready0", a_req_ready, 1);
    watch(45, 1, 1'b0, 8'h00);
    check_vec("rd_rsp_at", first_one(h_rv), 39);
    check_vec("rd_rsp_cnt", $countones(h_rv), 1);
    check_vec("rd_rdata", rdata_first, 8'h3C);
    check_vec("rd_rtcd_held", $countones(h_rt & h_cd), 39);
    check_vec("rd_rt_idle", h_rt[40], 0);
    check_vec("rd_le_cnt", $countones(h_le), 4);
    check_vec("rd_le_first", first_one(h_le), 1);
    check_vec("rd_rises", $countones(rises), 9);

    // CLK_DIV=2 write of 0xA5 to RD
    @(negedge clk);
    req_rt = 1'b0; req_cd = 1'b0; req_wdata = 8'hA5; a_req_valid = 1'b1;
    check_vec("wr_ready0", a_req_ready, 1);
    watch(45, 1, 1'b0, 8'h00);
    check_vec("wr_rsp_at", first_one(h_rv), 37);
    check_vec("wr_rsp_cnt", $countones(h_rv), 1);
    check_vec("wr_rises", $countones(rises), 8);
    check_vec("wr_bits", gather(rises, h_dout), 8'hA5);
    check_vec("wr_le_cnt", $countones(h_le), 2);
    check_vec("wr_le_first", first_one(h_le), 33);
    check_vec("wr_rtcd", $countones(h_rt | h_cd), 0);
    check_vec("wr_dout_tail", h_dout[37:33], 0);
    check_vec("wr_rdata_held", rdata_first, 8'h3C);

    // Reset during bit 4 of a write
    @(negedge clk);
    req_rt = 1'b0; req_cd = 1'b0; req_wdata = 8'h5A; a_req_valid = 1'b1;
    repeat (18) @(negedge clk);
    check_vec("mid_busy", a_busy, 1);
    check_vec("mid_dout_bit4", a_r_dout, 1);
    a_req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_vec("abort_pins", {a_r_clk, a_r_le, a_r_rt, a_r_cd, a_r_dout}, 0);
    check_vec("abort_state", {a_busy, a_req_ready, a_rsp_valid}, 3'b010);
    check_vec("abort_rdata", a_rsp_rdata, 8'h00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    watch(20, 0, 1'b0, 8'h00);
    check_vec("post_rst_le", $countones(h_le), 0);
    check_vec("post_rst_rsp", $countones(h_rv), 0);
    check_vec("post_rst_clk", $countones(h_ck), 0);
    @(negedge clk);
    a_tc = 8'h96; req_rt = 1'b1; req_cd = 1'b0; a_req_valid = 1'b1;
    watch(45, 1, 1'b0, 8'h00);
    check_vec("rd2_rsp_at", first_one(h_rv), 39);
    check_vec("rd2_rdata", rdata_first, 8'h96);
    check_vec("rd2_rt", $countones(h_rt), 39);
    check_vec("rd2_cd", $countones(h_cd), 0);

`ifdef TIPI_POLL_EN
    wait_busy(1'b1, n, pc, rv);
    wait_busy(1'b0, n, pc, rv);
    check_vec("poll_tc_zero", b_poll_tc, 8'h00);
    wait_busy(1'b1, n, pc, rv);
    check_vec("poll_gap", n, 8);
    check_vec("poll_rtcd", {b_r_rt, b_r_cd}, 2'b11);
    wait_busy(1'b0, n, pc, rv);
    check_vec("poll_len", n, 20);
    check_vec("poll_same_pulse", pc, 0);
    check_vec("poll_same_rsp", rv, 0);
    b_tc = 8'h81;
    wait_busy(1'b1, n, pc, rv);
    wait_busy(1'b0, n, pc, rv);
    check_vec("poll_chg_pulse", pc, 1);
    check_vec("poll_chg_rsp", rv, 0);
    check_vec("poll_tc_81", b_poll_tc, 8'h81);
    check_vec("poll_rdata_untouched", b_rsp_rdata, 8'h00);
    // host request arrives in the very cycle the poll would launch
    repeat (7) @(negedge clk);
    req_rt = 1'b0; req_cd = 1'b0; req_wdata = 8'h0F; b_req_valid = 1'b1;
    @(negedge clk);
    check_vec("race_busy", b_busy, 1);
    check_vec("race_host_rt", b_r_rt, 0);
    b_req_valid = 1'b0;
    wait_busy(1'b0, n, pc, rv);
    check_vec("race_wr_len", n, 19);
    check_vec("race_rsp", rv, 1);
    check_vec("race_no_pulse", pc, 0);
    wait_busy(1'b1, n, pc, rv);
    check_vec("race_idle_restart", n, 8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
